// File: rtl/tl_acquire_mshr_pkg.sv
// Shared TileLink-C bundle constants, grow/cap/permission encodings and MSHR state type
// for the L1 data cache Acquire miss handler.
package tl_acquire_mshr_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 128;
    localparam int unsigned SOURCE_W    = 3;
    localparam int unsigned SINK_W      = 4;
    localparam int unsigned SIZE_W      = 4;
    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned BEATS       = BLOCK_BYTES * 8 / DATA_W;
    localparam int unsigned BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFFSET_W    = $clog2(BLOCK_BYTES);

    localparam logic [SIZE_W-1:0] BLOCK_SIZE = SIZE_W'(OFFSET_W);

    localparam logic [2:0] OP_ACQUIRE_BLOCK = 3'd6;
    localparam logic [2:0] OP_ACQUIRE_PERM  = 3'd7;
    localparam logic [2:0] OP_GRANT         = 3'd4;
    localparam logic [2:0] OP_GRANT_DATA    = 3'd5;

    localparam logic [1:0] GROW_NTOB = 2'd0;
    localparam logic [1:0] GROW_NTOT = 2'd1;
    localparam logic [1:0] GROW_BTOT = 2'd2;

    localparam logic [1:0] CAP_TO_T = 2'd0;
    localparam logic [1:0] CAP_TO_B = 2'd1;
    localparam logic [1:0] CAP_TO_N = 2'd2;

    localparam logic [1:0] PERM_NOTHING = 2'd0;
    localparam logic [1:0] PERM_BRANCH  = 2'd1;
    localparam logic [1:0] PERM_TRUNK   = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StSendA,
        StWaitD,
        StSendE,
        StResp
    } mshr_state_e;

    // Any error collapses the grant to Nothing regardless of the cap received.
    function automatic logic [1:0] grant_perm(input logic err, input logic [1:0] cap);
        if (err) begin
            return PERM_NOTHING;
        end
        case (cap)
            CAP_TO_T: return PERM_TRUNK;
            CAP_TO_B: return PERM_BRANCH;
            default:  return PERM_NOTHING;
        endcase
    endfunction

endpackage

// File: rtl/tl_acquire_mshr_if.sv
// Cache request/response, TileLink A/D/E channels and refill write port of the Acquire MSHR.
// master is the MSHR side; slave is the cache pipeline plus interconnect side.
interface tl_acquire_mshr_if;
    import tl_acquire_mshr_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_W-1:0]     req_addr;
    logic [1:0]            req_grow;
    logic                  req_perm;

    logic                  a_valid;
    logic                  a_ready;
    logic [2:0]            a_opcode;
    logic [1:0]            a_param;
    logic [SIZE_W-1:0]     a_size;
    logic [SOURCE_W-1:0]   a_source;
    logic [ADDR_W-1:0]     a_address;
    logic [DATA_W/8-1:0]   a_mask;

    logic                  d_valid;
    logic                  d_ready;
    logic [2:0]            d_opcode;
    logic [1:0]            d_param;
    logic [SOURCE_W-1:0]   d_source;
    logic [SINK_W-1:0]     d_sink;
    logic                  d_denied;
    logic [DATA_W-1:0]     d_data;

    logic                  refill_valid;
    logic [BEAT_W-1:0]     refill_beat;
    logic [DATA_W-1:0]     refill_data;

    logic                  e_valid;
    logic                  e_ready;
    logic [SINK_W-1:0]     e_sink;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [1:0]            resp_perm;
    logic                  resp_err;

    modport master (
        input  req_valid, req_addr, req_grow, req_perm,
        output req_ready,
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_source, d_sink, d_denied, d_data,
        output d_ready,
        output refill_valid, refill_beat, refill_data,
        output e_valid, e_sink,
        input  e_ready,
        output resp_valid, resp_perm, resp_err,
        input  resp_ready
    );

    modport slave (
        output req_valid, req_addr, req_grow, req_perm,
        input  req_ready,
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
        output a_ready,
        output d_valid, d_opcode, d_param, d_source, d_sink, d_denied, d_data,
        input  d_ready,
        input  refill_valid, refill_beat, refill_data,
        input  e_valid, e_sink,
        output e_ready,
        input  resp_valid, resp_perm, resp_err,
        output resp_ready
    );

endinterface

// File: rtl/tl_acquire_mshr.sv
// Single-entry TileLink-C Acquire miss handler: Acquire on A, Grant/GrantData on D with
// streamed refill beats, GrantAck on E, then a held permission response to the cache.
module tl_acquire_mshr
    import tl_acquire_mshr_pkg::*;
#(
    parameter int unsigned SOURCE_ID = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    tl_acquire_mshr_if.master bus
);

    localparam logic [SOURCE_W-1:0] SRC         = SOURCE_W'(SOURCE_ID);
    localparam logic [BEAT_W-1:0]   LAST_BEAT   = BEAT_W'(BEATS - 1);

    mshr_state_e          state_q;
    logic                 req_ready_q;
    logic                 a_valid_q;
    logic                 e_valid_q;
    logic                 resp_valid_q;
    logic                 resp_err_q;
    logic [1:0]           resp_perm_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [1:0]           grow_q;
    logic                 perm_q;
    logic [SINK_W-1:0]    sink_q;
    logic [1:0]           cap_q;
    logic                 err_q;
    logic [BEAT_W-1:0]    beat_q;

    logic d_accept;
    logic d_fire;
    logic d_last;
    logic d_mismatch;

    // Beats for other sources are left on the channel for their owner.
    assign d_accept   = (state_q == StWaitD) && (bus.d_source == SRC);
    assign d_fire     = bus.d_valid && d_accept;
    assign d_last     = (bus.d_opcode != OP_GRANT_DATA) || (beat_q == LAST_BEAT);
    assign d_mismatch = perm_q ? (bus.d_opcode != OP_GRANT) : (bus.d_opcode != OP_GRANT_DATA);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            req_ready_q  <= 1'b1;
            a_valid_q    <= 1'b0;
            e_valid_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_perm_q  <= PERM_NOTHING;
            addr_q       <= '0;
            grow_q       <= '0;
            perm_q       <= 1'b0;
            sink_q       <= '0;
            cap_q        <= '0;
            err_q        <= 1'b0;
            beat_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        addr_q      <= {bus.req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        grow_q      <= bus.req_grow;
                        perm_q      <= bus.req_perm;
                        err_q       <= 1'b0;
                        beat_q      <= '0;
                        req_ready_q <= 1'b0;
                        a_valid_q   <= 1'b1;
                        state_q     <= StSendA;
                    end
                end
                StSendA: begin
                    if (bus.a_ready) begin
                        a_valid_q <= 1'b0;
                        state_q   <= StWaitD;
                    end
                end
                StWaitD: begin
                    if (d_fire) begin
                        if (d_last) begin
                            sink_q    <= bus.d_sink;
                            cap_q     <= bus.d_param;
                            err_q     <= err_q | bus.d_denied | d_mismatch
                                       | (bus.d_param == CAP_TO_N);
                            beat_q    <= '0;
                            e_valid_q <= 1'b1;
                            state_q   <= StSendE;
                        end else begin
                            err_q  <= err_q | bus.d_denied;
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StSendE: begin
                    if (bus.e_ready) begin
                        e_valid_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q;
                        resp_perm_q  <= grant_perm(err_q, cap_q);
                        state_q      <= StResp;
                    end
                end
                StResp: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        err_q        <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;

    assign bus.a_valid   = a_valid_q;
    assign bus.a_opcode  = perm_q ? OP_ACQUIRE_PERM : OP_ACQUIRE_BLOCK;
    assign bus.a_param   = grow_q;
    assign bus.a_size    = BLOCK_SIZE;
    assign bus.a_source  = SRC;
    assign bus.a_address = addr_q;
    assign bus.a_mask    = '1;

    assign bus.d_ready   = d_accept;

    // A denied beat poisons itself and every later beat of the block.
    assign bus.refill_valid = d_fire && (bus.d_opcode == OP_GRANT_DATA) && !perm_q
                              && !err_q && !bus.d_denied;
    assign bus.refill_beat  = beat_q;
    assign bus.refill_data  = bus.d_data;

    assign bus.e_valid    = e_valid_q;
    assign bus.e_sink     = sink_q;

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_perm  = resp_perm_q;
    assign bus.resp_err   = resp_err_q;

endmodule
